// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core, with load-use hazard detection,
// flush/busy handling and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic [1:0]      id_wb_sel,
    input  logic            flush,
    input  logic            ex_busy,
    output logic            stall_if_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic [1:0]      ex_wb_sel,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic lu_hazard;
    logic load_bubble;

    // A load to x0 never produces a value worth waiting for.
    assign lu_hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));

    assign stall_if_id = (lu_hazard & ~flush) | ex_busy;
    assign load_bubble = ~ex_busy & (flush | lu_hazard);

    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_alu_op    <= 4'd0;
            ex_alu_src   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_wb_sel    <= 2'd0;
        end else if (!ex_busy) begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1_data  <= id_rs1_data;
            ex_rs2_data  <= id_rs2_data;
            ex_imm       <= id_imm;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_alu_op    <= id_alu_op;
            ex_alu_src   <= id_alu_src;
            // An empty slot must never touch memory, write back or forward.
            ex_mem_read  <= id_valid & id_mem_read;
            ex_mem_write <= id_valid & id_mem_write;
            ex_reg_write <= id_valid & id_reg_write;
            ex_wb_sel    <= id_wb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!ex_busy && !flush && lu_hazard && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
